pc16_stack: RTL

- 16-bit program counter with a small hardware return-address stack.
- Sits directly downstream of the 16-bit 2:1 mux: the mux output (jump target) drives `in`.
- Registers the next instruction address each cycle: hold, increment, jump, call (jump + push return address) or return (pop).
- First sequential stage after the basic-gates layer; feeds the instruction-memory address.

---
 rtl/pc16_stack_if.sv | 25 ++
 rtl/pc16_stack.sv | 100 ++++++++++
 2 files changed

// File: rtl/pc16_stack_if.sv
// Command/status bundle between the jump-target mux, the program counter and
// the instruction-memory address port.
interface pc16_stack_if #(
  parameter int WIDTH = 16
);
  logic [WIDTH-1:0] in;
  logic             load;
  logic             inc;
  logic             call;
  logic             ret;
  logic [WIDTH-1:0] out;
  logic             stk_empty;
  logic             stk_full;
  logic             err;

  modport master (
    output in, load, inc, call, ret,
    input  out, stk_empty, stk_full, err
  );

  modport slave (
    input  in, load, inc, call, ret,
    output out, stk_empty, stk_full, err
  );
endinterface

// File: rtl/pc16_stack.sv
// Program counter with a LIFO return-address stack (load > call > ret > inc > hold).
// Optional macro PC16_HALT_EN adds a `halt` input that freezes all state.
module pc16_stack #(
  parameter int               WIDTH     = 16,
  parameter int               DEPTH     = 4,
  parameter logic [WIDTH-1:0] RESET_VEC = '0
) (
  input  logic         clk,
  input  logic         rst_n,
`ifdef PC16_HALT_EN
  input  logic         halt,
`endif
  pc16_stack_if.slave  bus
);

  localparam int PTR_W = $clog2(DEPTH + 1);
  localparam int IDX_W = $clog2(DEPTH);

  function automatic logic [WIDTH-1:0] wrap_inc(input logic [WIDTH-1:0] v);
    return v + WIDTH'(1);
  endfunction

  logic [WIDTH-1:0] stack_mem [DEPTH];
  logic [WIDTH-1:0] pc_p0, pc_nxt;
  logic [PTR_W-1:0] ptr_p0, ptr_nxt;
  logic             err_p0, err_nxt;
  logic             empty_p0, full_p0;
  logic             push_en;
  logic [IDX_W-1:0] push_idx, top_idx;
  logic             halt_i;

`ifdef PC16_HALT_EN
  assign halt_i = halt;
`else
  assign halt_i = 1'b0;
`endif

  assign push_idx = IDX_W'(ptr_p0);
  assign top_idx  = IDX_W'(ptr_p0 - PTR_W'(1));

  // Only the highest-priority asserted command may touch the stack.
  always_comb begin
    pc_nxt  = pc_p0;
    ptr_nxt = ptr_p0;
    err_nxt = err_p0;
    push_en = 1'b0;
    if (!halt_i) begin
      if (bus.load) begin
        pc_nxt = bus.in;
      end else if (bus.call) begin
        pc_nxt = bus.in;
        if (ptr_p0 != PTR_W'(DEPTH)) begin
          push_en = 1'b1;
          ptr_nxt = ptr_p0 + PTR_W'(1);
        end else begin
          err_nxt = 1'b1;
        end
      end else if (bus.ret) begin
        if (ptr_p0 != '0) begin
          pc_nxt  = stack_mem[top_idx];
          ptr_nxt = ptr_p0 - PTR_W'(1);
        end else begin
          err_nxt = 1'b1;
        end
      end else if (bus.inc) begin
        pc_nxt = wrap_inc(pc_p0);
      end
    end
  end

  // Stage p0: control state and registered flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_p0    <= RESET_VEC;
      ptr_p0   <= '0;
      err_p0   <= 1'b0;
      empty_p0 <= 1'b1;
      full_p0  <= 1'b0;
    end else begin
      pc_p0    <= pc_nxt;
      ptr_p0   <= ptr_nxt;
      err_p0   <= err_nxt;
      empty_p0 <= (ptr_nxt == '0);
      full_p0  <= (ptr_nxt == PTR_W'(DEPTH));
    end
  end

  // Stack storage carries data only, so it is left out of reset.
  always_ff @(posedge clk) begin
    if (push_en) begin
      stack_mem[push_idx] <= wrap_inc(pc_p0);
    end
  end

  assign bus.out       = pc_p0;
  assign bus.stk_empty = empty_p0;
  assign bus.stk_full  = full_p0;
  assign bus.err       = err_p0;

endmodule
